fp_divider: RTL and testbench

- Sequential signed fixed-point divider (Qm.FRACTIONAL_BITS) that computes dout = din_1 / din_2, the inverse of the team's combinational fixed-point add/multiply operator.
- Uses radix-2 restoring division on operand magnitudes, one quotient bit per clock, then applies the sign, saturation and divide-by-zero handling.
- Sits beside the add/multiply operator in the datapath and uses a start/valid handshake.

---
 rtl/fp_divider_if.sv | 25 ++
 rtl/fp_divider.sv | 148 ++++++++++++++
 tb/tb_fp_divider.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_divider_if.sv
// Start/valid handshake bundle between a requester and the fixed-point divider.
interface fp_divider_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_start;
    logic [DATA_WIDTH-1:0] din_1;
    logic [DATA_WIDTH-1:0] din_2;
    logic                  o_busy;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] dout;
    logic                  o_div_zero;
    logic                  o_ovf;

    // Handshake: i_start is taken on a rising edge only while o_busy=0; o_valid is a
    // one-cycle pulse and dout/o_div_zero/o_ovf hold their value until the next result.
    modport master (
        output i_start, din_1, din_2,
        input  o_busy, o_valid, dout, o_div_zero, o_ovf
    );

    modport slave (
        input  i_start, din_1, din_2,
        output o_busy, o_valid, dout, o_div_zero, o_ovf
    );
endinterface

// File: rtl/fp_divider.sv
// Sequential signed fixed-point divider: restoring radix-2 on magnitudes, one quotient
// bit per clock, then sign, saturation and divide-by-zero handling.
module fp_divider #(
    parameter int DATA_WIDTH      = 32,
    parameter int FRACTIONAL_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_divider_if.slave bus,
    output logic [1:0]  dbg_state
);
    localparam int N  = DATA_WIDTH + FRACTIONAL_BITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [N-1:0] POS_LIM = {{(FRACTIONAL_BITS+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [N-1:0] NEG_LIM = {{FRACTIONAL_BITS{1'b0}}, MIN_NEG};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N-1:0]          d_q, d_d;
    logic [N-1:0]          q_q, q_d;
    logic [DATA_WIDTH:0]   r_q, r_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  neg_q, neg_d;
    logic                  a_neg_q, a_neg_d;
    logic                  dz_q, dz_d;
    logic                  div_zero_q, div_zero_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] a_abs, b_abs, q_low;
    logic [DATA_WIDTH+1:0] r_sh, r_sub;
    logic                  r_ge;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        d_d        = d_q;
        q_d        = q_q;
        r_d        = r_q;
        b_d        = b_q;
        dout_d     = dout_q;
        neg_d      = neg_q;
        a_neg_d    = a_neg_q;
        dz_d       = dz_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        a_abs = bus.din_1[DATA_WIDTH-1] ? -bus.din_1 : bus.din_1;
        b_abs = bus.din_2[DATA_WIDTH-1] ? -bus.din_2 : bus.din_2;
        // r always stays below b, so shifting in one dividend bit cannot lose information.
        r_sh  = {r_q, d_q[N-1]};
        r_ge  = r_sh >= {2'b00, b_q};
        r_sub = r_sh - {2'b00, b_q};
        q_low = q_q[DATA_WIDTH-1:0];

        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    d_d     = {a_abs, {FRACTIONAL_BITS{1'b0}}};
                    b_d     = b_abs;
                    r_d     = '0;
                    q_d     = '0;
                    neg_d   = bus.din_1[DATA_WIDTH-1] ^ bus.din_2[DATA_WIDTH-1];
                    a_neg_d = bus.din_1[DATA_WIDTH-1];
                    dz_d    = (bus.din_2 == '0);
                    // A zero divisor skips the iterations and resolves on the next edge.
                    cnt_d   = (bus.din_2 == '0) ? '0 : CW'(N);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    r_d   = r_ge ? (DATA_WIDTH+1)'(r_sub) : (DATA_WIDTH+1)'(r_sh);
                    q_d   = {q_q[N-2:0], r_ge};
                    d_d   = {d_q[N-2:0], 1'b0};
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d    = DONE;
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b0;
                    if (dz_q) begin
                        dout_d     = a_neg_q ? MIN_NEG : MAX_POS;
                        div_zero_d = 1'b1;
                    end else if (!neg_q && (q_q > POS_LIM)) begin
                        dout_d = MAX_POS;
                        ovf_d  = 1'b1;
                    end else if (neg_q && (q_q > NEG_LIM)) begin
                        dout_d = MIN_NEG;
                        ovf_d  = 1'b1;
                    end else begin
                        dout_d = neg_q ? -q_low : q_low;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            d_q        <= '0;
            q_q        <= '0;
            r_q        <= '0;
            b_q        <= '0;
            dout_q     <= '0;
            neg_q      <= 1'b0;
            a_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            d_q        <= d_d;
            q_q        <= q_d;
            r_q        <= r_d;
            b_q        <= b_d;
            dout_q     <= dout_d;
            neg_q      <= neg_d;
            a_neg_q    <= a_neg_d;
            dz_q       <= dz_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_valid    = (state_q == DONE);
    assign bus.dout       = dout_q;
    assign bus.o_div_zero = div_zero_q;
    assign bus.o_ovf      = ovf_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed cases, handshake and reset corners, then random
// operands checked against an arithmetic reference model.
module tb_fp_divider;
  localparam int DW = 32;
  localparam int FB = 16;
  localparam int N  = DW + FB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [DW-1:0] exp_q[$];

  fp_divider_if #(.DATA_WIDTH(DW)) bus ();

  fp_divider #(.DATA_WIDTH(DW), .FRACTIONAL_BITS(FB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer quotient of the scaled magnitudes, then the result rules.
  function automatic void ref_div(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                  output logic [DW-1:0] e_dout, output logic e_dz,
                                  output logic e_ovf);
    longint xs, ys, ax, ay, q, res, max_pos, min_mag;
    logic [63:0] res_bits;
    bit neg;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    max_pos = (longint'(1) <<< (DW - 1)) - 1;
    min_mag = longint'(1) <<< (DW - 1);
    e_dz = 1'b0;
    e_ovf = 1'b0;
    if (ys == 0) begin
      e_dz = 1'b1;
      res = (xs >= 0) ? max_pos : -min_mag;
    end else begin
      ax = (xs < 0) ? -xs : xs;
      ay = (ys < 0) ? -ys : ys;
      q = (ax * (longint'(1) <<< FB)) / ay;
      neg = (xs < 0) != (ys < 0);
      if (!neg && q > max_pos) begin
        res = max_pos;
        e_ovf = 1'b1;
      end else if (neg && q > min_mag) begin
        res = -min_mag;
        e_ovf = 1'b1;
      end else begin
        res = neg ? -q : q;
      end
    end
    res_bits = res;
    e_dout = res_bits[DW-1:0];
  endfunction

  // Accept on the next edge, scramble the inputs, optionally poke i_start at edge poke_at,
  // and wait (bounded) for o_valid; lat is the edge count after accept, 0 on timeout.
  task automatic run_div(input logic [DW-1:0] x, input logic [DW-1:0] y, input int poke_at,
                         output logic [DW-1:0] got, output logic gdz, output logic govf,
                         output int lat);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.din_1 = x;
    bus.din_2 = y;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.din_1 = $urandom;
    bus.din_2 = $urandom;
    lat = 0;
    got = '0;
    gdz = 1'b0;
    govf = 1'b0;
    for (int k = 1; k <= N + 20; k++) begin
      if (k == poke_at) begin
        bus.i_start = 1'b1;
        bus.din_1 = $urandom;
        bus.din_2 = $urandom_range(1, 255);
      end
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      if (bus.o_valid) begin
        lat = k;
        got = bus.dout;
        gdz = bus.o_div_zero;
        govf = bus.o_ovf;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input int poke_at, output logic [DW-1:0] got);
    logic [DW-1:0] e_dout, exp_dout;
    logic e_dz, e_ovf, gdz, govf;
    int lat;
    ref_div(x, y, e_dout, e_dz, e_ovf);
    exp_q.push_back(e_dout);
    run_div(x, y, poke_at, got, gdz, govf, lat);
    exp_dout = exp_q.pop_front();
    check({tag, "_lat"}, lat, e_dz ? 1 : N + 1);
    check({tag, "_dout"}, got, exp_dout);
    check({tag, "_dz"}, gdz, e_dz);
    check({tag, "_ovf"}, govf, e_ovf);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {bus.o_valid, bus.o_busy}, 2'b00);
  endtask

  task automatic count_valids(input int cycles, output int vc);
    vc = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) vc++;
    end
  endtask

  logic [DW-1:0] dir_x [10] = '{32'h00030000, 32'hFFFE8000, 32'h00010000, 32'hFFFF0000,
                                32'h00000000, 32'h00050000, 32'hFFFB0000, 32'h7FFF0000,
                                32'h80000000, 32'h80000000};
  logic [DW-1:0] dir_y [10] = '{32'h00020000, 32'h00008000, 32'h00030000, 32'h00030000,
                                32'hFFFF0000, 32'h00000000, 32'h00000000, 32'h00000100,
                                32'h00010000, 32'hFFFF0000};
  logic [DW-1:0] dir_d [10] = '{32'h00018000, 32'hFFFD0000, 32'h00005555, 32'hFFFFAAAB,
                                32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                                32'h80000000, 32'h7FFFFFFF};

  initial begin
    logic [DW-1:0] got, x, y;
    int vc;

    // clock/reset
    bus.i_start = 1'b0;
    bus.din_1 = '0;
    bus.din_2 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_dout", bus.dout, '0);
    check("rst_dz", bus.o_div_zero, 1'b0);
    check("rst_ovf", bus.o_ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed values
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("dir%0d", i), dir_x[i], dir_y[i], -1, got);
      check($sformatf("dir%0d_const", i), got, dir_d[i]);
    end

    // i_start during a busy division is dropped; next accept right after DONE works
    do_op("hs", 32'h00030000, 32'h00020000, 10, got);
    check("hs_const", got, 32'h00018000);
    do_op("b2b", 32'hFFFF0000, 32'h00030000, -1, got);
    check("b2b_const", got, 32'hFFFFAAAB);
    count_valids(N + 10, vc);
    check("hs_no_extra_valid", vc, 0);

    // reset in the middle of a division
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.din_1 = 32'h00050000;
    bus.din_2 = 32'h00000300;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    vc = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) vc++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", bus.o_busy, 1'b0);
    check("mid_rst_valid", bus.o_valid, 1'b0);
    check("mid_rst_dout", bus.dout, '0);
    check("mid_rst_flags", {bus.o_div_zero, bus.o_ovf}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    count_valids(N + 10, x);
    check("mid_rst_no_valid", vc + int'(x), 0);
    do_op("post_rst", 32'h00010000, 32'h00010000, -1, got);
    check("post_rst_const", got, 32'h00010000);

    // random operands against the reference model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: begin x = $urandom; y = $urandom; end
        1: begin x = $urandom_range(0, 32'h0003FFFF) - 32'h00020000; y = $urandom; end
        2: begin x = $urandom; y = '0; end
        3: begin x = 32'h80000000; y = $urandom; end
        4: begin
          x = $urandom_range(0, 32'h001FFFFF) - 32'h00100000;
          y = $urandom_range(0, 32'h001FFFFF) - 32'h00100000;
        end
        default: begin
          x = $urandom;
          y = $urandom_range(1, 32'h200);
          if ($urandom_range(0, 1) == 1) y = -y;
        end
      endcase
      do_op($sformatf("rnd%0d", i), x, y, -1, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
